// File: rtl/cruise_pkg.sv
// rtl/cruise_pkg.sv - shared constants and types for the cruise sequencer and its ALU
//
// Purpose: ALU mode codes (shared with the speed ALU), sequencer state enum,
//          speed step size and a small helper that classifies engaged states.
// Ports:   none (package).
package cruise_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_CMP  = 2'b01;
  localparam logic [1:0] MODE_ADD5 = 2'b10;
  localparam logic [1:0] MODE_SUB5 = 2'b11;

  localparam logic [7:0] SPEED_STEP = 8'd5;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_CMP_ISSUE,
    ST_CMP_EVAL,
    ST_ADJ_ISSUE,
    ST_ADJ_CAP
  } state_t;

  function automatic logic is_engaged(input state_t s);
    return (s == ST_CMP_ISSUE) || (s == ST_CMP_EVAL) ||
           (s == ST_ADJ_ISSUE) || (s == ST_ADJ_CAP);
  endfunction

endpackage

// File: rtl/cruise_step_timer.sv
// rtl/cruise_step_timer.sv - pacing timer for held accel/coast steps
//
// Purpose: spaces successive desired-speed steps STEP_CYCLES cycles apart
//          while a step button is held; the first step after a fresh press
//          is allowed immediately.
// Ports:
//   clock    in  1  clock, posedge
//   reset    in  1  synchronous, active-high
//   hold     in  1  accel or coast currently held
//   restart  in  1  a step was just captured; begin a new interval
//   expired  out 1  a step may be taken now
module cruise_step_timer #(
  parameter int STEP_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic restart,
  output logic expired
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;
  // Set while no step has been taken since the button went down, so the
  // very first step of a press does not wait out a full interval.
  logic          armed;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= RELOAD;
      armed <= 1'b1;
    end else if (!hold) begin
      count <= RELOAD;
      armed <= 1'b1;
    end else if (restart) begin
      count <= RELOAD;
      armed <= 1'b0;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign expired = armed || (count == '0);

endmodule

// File: rtl/cruise_sequencer.sv
// rtl/cruise_sequencer.sv - cruise-control sequencer driving the speed ALU
//
// Purpose: owns the desired-speed register, sequences CMP / ADD5 / SUB5
//          operations on the ALU and turns compare results into throttle
//          requests.
// Ports:
//   clock, reset               in   1  clock (posedge), sync active-high reset
//   enable                     in   1  master cruise switch
//   set, resume                in   1  one-cycle pulses
//   accel, coast               in   1  held step buttons
//   brake, cancel              in   1  disengage requests
//   c_speed                    in   8  current speed
//   alu_mode                   out  2  ALU mode code
//   alu_d_speed                out  8  desired speed to the ALU
//   alu_out_speed              in   8  ALU registered result
//   alu_L, alu_EQ, alu_G       in   1  ALU registered compare flags
//   cruise_active              out  1  engaged
//   throttle_up, throttle_down out  1  throttle requests
//   d_valid                    out  1  desired speed usable by resume
module cruise_sequencer
  import cruise_pkg::*;
#(
  parameter logic [7:0] MIN_SPEED   = 8'd40,
  parameter logic [7:0] MAX_SPEED   = 8'd200,
  parameter int         STEP_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       set,
  input  logic       resume,
  input  logic       accel,
  input  logic       coast,
  input  logic       brake,
  input  logic       cancel,
  input  logic [7:0] c_speed,
  output logic [1:0] alu_mode,
  output logic [7:0] alu_d_speed,
  input  logic [7:0] alu_out_speed,
  input  logic       alu_L,
  input  logic       alu_EQ,
  input  logic       alu_G,
  output logic       cruise_active,
  output logic       throttle_up,
  output logic       throttle_down,
  output logic       d_valid
);

  state_t     state, next_state;
  logic [7:0] d_speed, d_speed_next;
  logic       d_valid_next;
  logic       up_next, down_next;
  logic       step_up, step_up_next;

  logic hold, disengage, set_ok, up_ok, down_ok, step_expired;

  assign hold      = accel | coast;
  assign disengage = brake | cancel;
  assign set_ok    = set && (c_speed >= MIN_SPEED) && (c_speed <= MAX_SPEED);
  // Range guards keep the desired speed inside [MIN, MAX] and away from 8-bit wrap.
  assign up_ok     = accel && !coast && (d_speed <= MAX_SPEED - SPEED_STEP);
  assign down_ok   = coast && !accel && (d_speed >= MIN_SPEED + SPEED_STEP);

  cruise_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clock   (clock),
    .reset   (reset),
    .hold    (hold),
    .restart (state == ST_ADJ_CAP),
    .expired (step_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_OFF;
      d_speed       <= 8'd0;
      d_valid       <= 1'b0;
      throttle_up   <= 1'b0;
      throttle_down <= 1'b0;
      step_up       <= 1'b0;
      cruise_active <= 1'b0;
    end else begin
      state         <= next_state;
      d_speed       <= d_speed_next;
      d_valid       <= d_valid_next;
      throttle_up   <= up_next;
      throttle_down <= down_next;
      step_up       <= step_up_next;
      cruise_active <= is_engaged(next_state);
    end
  end

  always_comb begin
    next_state   = state;
    d_speed_next = d_speed;
    d_valid_next = d_valid;
    up_next      = throttle_up;
    down_next    = throttle_down;
    step_up_next = step_up;

    alu_mode = MODE_PASS;
    if (state == ST_CMP_ISSUE) alu_mode = MODE_CMP;
    if (state == ST_ADJ_ISSUE) alu_mode = step_up ? MODE_ADD5 : MODE_SUB5;

    if (!enable) begin
      next_state   = ST_OFF;
      d_speed_next = 8'd0;
      d_valid_next = 1'b0;
      up_next      = 1'b0;
      down_next    = 1'b0;
    end else if (state == ST_OFF) begin
      next_state = ST_IDLE;
    end else if (disengage) begin
      // Leaving ADJ_ISSUE here drops the in-flight ALU result unused.
      next_state = ST_IDLE;
      up_next    = 1'b0;
      down_next  = 1'b0;
    end else begin
      if (state == ST_CMP_EVAL) begin
        up_next   = alu_L && !alu_EQ;
        down_next = alu_G && !alu_EQ;
      end
      if (set_ok) begin
        d_speed_next = c_speed;
        d_valid_next = 1'b1;
        next_state   = ST_CMP_ISSUE;
      end else if (resume && (state == ST_IDLE) && d_valid) begin
        next_state = ST_CMP_ISSUE;
      end else begin
        case (state)
          ST_CMP_ISSUE: next_state = ST_CMP_EVAL;
          ST_CMP_EVAL: begin
            if (step_expired && up_ok) begin
              next_state   = ST_ADJ_ISSUE;
              step_up_next = 1'b1;
            end else if (step_expired && down_ok) begin
              next_state   = ST_ADJ_ISSUE;
              step_up_next = 1'b0;
            end else begin
              next_state = ST_CMP_ISSUE;
            end
          end
          ST_ADJ_ISSUE: next_state = ST_ADJ_CAP;
          ST_ADJ_CAP: begin
            d_speed_next = alu_out_speed;
            next_state   = ST_CMP_ISSUE;
          end
          default: ;
        endcase
      end
    end
  end

  assign alu_d_speed = d_speed;

endmodule

// File: tb/tb_cruise_sequencer.sv
// tb/tb_cruise_sequencer.sv - randomized self-checking bench for cruise_sequencer
module tb_cruise_sequencer;

  localparam int STEP  = 4;
  localparam int VMIN  = 40;
  localparam int VMAX  = 200;

  // Reference-model phases (bench-local numbering).
  localparam int P_OFF = 0, P_IDLE = 1, P_CI = 2, P_CE = 3, P_AI = 4, P_CAP = 5;

  logic       clock = 1'b0;
  logic       reset, enable, set, resume, accel, coast, brake, cancel;
  logic [7:0] c_speed;
  logic [1:0] alu_mode;
  logic [7:0] alu_d_speed, alu_out_speed;
  logic       alu_L, alu_EQ, alu_G;
  logic       cruise_active, throttle_up, throttle_down, d_valid;

  int n_cmp = 0;
  int n_err = 0;

  cruise_sequencer #(
    .MIN_SPEED   (8'd40),
    .MAX_SPEED   (8'd200),
    .STEP_CYCLES (STEP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .set           (set),
    .resume        (resume),
    .accel         (accel),
    .coast         (coast),
    .brake         (brake),
    .cancel        (cancel),
    .c_speed       (c_speed),
    .alu_mode      (alu_mode),
    .alu_d_speed   (alu_d_speed),
    .alu_out_speed (alu_out_speed),
    .alu_L         (alu_L),
    .alu_EQ        (alu_EQ),
    .alu_G         (alu_G),
    .cruise_active (cruise_active),
    .throttle_up   (throttle_up),
    .throttle_down (throttle_down),
    .d_valid       (d_valid)
  );

  always #5 clock = ~clock;

  // Speed ALU stub: one-edge latency, flags only meaningful after CMP.
  always @(posedge clock) begin
    if (reset) begin
      alu_out_speed <= 8'd0;
      alu_L <= 1'b0; alu_EQ <= 1'b0; alu_G <= 1'b0;
    end else begin
      alu_L <= 1'b0; alu_EQ <= 1'b0; alu_G <= 1'b0;
      case (alu_mode)
        2'b01: begin
          alu_out_speed <= c_speed;
          alu_L  <= c_speed <  alu_d_speed;
          alu_EQ <= c_speed == alu_d_speed;
          alu_G  <= c_speed >  alu_d_speed;
        end
        2'b10:   alu_out_speed <= alu_d_speed + 8'd5;
        2'b11:   alu_out_speed <= alu_d_speed - 8'd5;
        default: alu_out_speed <= c_speed;
      endcase
    end
  end

  // Reference model state.
  int m_ph = P_OFF, m_d = 0, m_dir = 1, m_el = 0, m_prev_c = 0;
  bit m_v = 0, m_tu = 0, m_td = 0, m_armed = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    int  ph, d, dir, el, c;
    bit  v, tu, td, armed, held, brk, expired, can_up, can_dn;
    c    = int'(c_speed);
    held = accel || coast;
    brk  = brake || cancel;
    if (reset) begin
      m_ph = P_OFF; m_d = 0; m_v = 0; m_tu = 0; m_td = 0;
      m_dir = 1; m_armed = 1; m_el = 0; m_prev_c = c;
      return;
    end
    ph = m_ph; d = m_d; v = m_v; tu = m_tu; td = m_td; dir = m_dir;
    expired = m_armed || (m_el >= STEP - 1);
    can_up  = accel && !coast && (m_d + 5 <= VMAX);
    can_dn  = coast && !accel && (m_d - 5 >= VMIN);
    if (!enable) begin
      ph = P_OFF; d = 0; v = 0; tu = 0; td = 0;
    end else if (m_ph == P_OFF) begin
      ph = P_IDLE;
    end else if (brk) begin
      ph = P_IDLE; tu = 0; td = 0;
    end else begin
      if (m_ph == P_CE) begin
        tu = m_prev_c < m_d;
        td = m_prev_c > m_d;
      end
      if (set && c >= VMIN && c <= VMAX) begin
        d = c; v = 1; ph = P_CI;
      end else if (resume && m_ph == P_IDLE && m_v) begin
        ph = P_CI;
      end else if (m_ph == P_CI) begin
        ph = P_CE;
      end else if (m_ph == P_CE) begin
        if (expired && can_up)      begin ph = P_AI; dir = 1;  end
        else if (expired && can_dn) begin ph = P_AI; dir = -1; end
        else                              ph = P_CI;
      end else if (m_ph == P_AI) begin
        ph = P_CAP;
      end else if (m_ph == P_CAP) begin
        d = m_d + 5 * m_dir; ph = P_CI;
      end
    end
    armed = m_armed; el = m_el;
    if (!held)               begin armed = 1; el = 0; end
    else if (m_ph == P_CAP)  begin armed = 0; el = 0; end
    else                     el = m_el + 1;
    m_ph = ph; m_d = d; m_v = v; m_tu = tu; m_td = td; m_dir = dir;
    m_armed = armed; m_el = el; m_prev_c = c;
  endtask

  task automatic tick();
    logic [1:0] em;
    @(posedge clock);
    model_step();
    #1;
    em = 2'b00;
    if (m_ph == P_CI) em = 2'b01;
    if (m_ph == P_AI) em = (m_dir > 0) ? 2'b10 : 2'b11;
    check_eq("alu_mode",      alu_mode,      em);
    check_eq("alu_d_speed",   alu_d_speed,   m_d);
    check_eq("cruise_active", cruise_active, (m_ph >= P_CI));
    check_eq("throttle_up",   throttle_up,   m_tu);
    check_eq("throttle_down", throttle_down, m_td);
    check_eq("d_valid",       d_valid,       m_v);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_set(input int c);
    c_speed = 8'(c);
    set = 1'b1;
    tick();
    set = 1'b0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; enable = 1'b0; set = 1'b0; resume = 1'b0;
    accel = 1'b0; coast = 1'b0; brake = 1'b0; cancel = 1'b0; c_speed = 8'd0;
    run(2);
    reset = 1'b0;
    check_eq("rst_d_speed", alu_d_speed, 0);
    check_eq("rst_active",  cruise_active, 0);
    check_eq("rst_mode",    alu_mode, 0);

    // Set at 60 with matching speed: engage, both throttles idle.
    enable = 1'b1;
    tick();
    c_speed = 8'd60;
    pulse_set(60);
    check_eq("set60_d", alu_d_speed, 60);
    tick();
    check_eq("set60_active", cruise_active, 1);
    run(6);
    check_eq("eq_up",   throttle_up,   0);
    check_eq("eq_down", throttle_down, 0);

    // Below and above desired speed.
    c_speed = 8'd55; run(4);
    check_eq("slow_up",   throttle_up,   1);
    check_eq("slow_down", throttle_down, 0);
    c_speed = 8'd70; run(4);
    check_eq("fast_up",   throttle_up,   0);
    check_eq("fast_down", throttle_down, 1);

    // Accel from 190 saturates at 200.
    pulse_set(190);
    accel = 1'b1; run(30);
    check_eq("accel_cap", alu_d_speed, 200);
    accel = 1'b0; run(2);

    // Coast from 47: one step to 42, then blocked.
    pulse_set(47);
    coast = 1'b1; run(30);
    check_eq("coast_floor", alu_d_speed, 42);
    coast = 1'b0; run(2);

    // Out-of-range set ignored.
    pulse_set(30);
    pulse_set(210);
    run(2);
    check_eq("set_oor", alu_d_speed, 42);

    // Brake during ADJ_ISSUE discards the step; resume re-engages at 100.
    pulse_set(100);
    accel = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (alu_mode == 2'b10) found = 1;
    end
    check_eq("adj_issue_seen", found, 1);
    brake = 1'b1; tick(); brake = 1'b0; accel = 1'b0;
    check_eq("brake_active", cruise_active, 0);
    check_eq("brake_d",      alu_d_speed,   100);
    run(3);
    resume = 1'b1; tick(); resume = 1'b0;
    check_eq("resume_active", cruise_active, 1);
    check_eq("resume_d",      alu_d_speed,   100);
    run(4);

    // Enable off clears validity; resume then ignored.
    enable = 1'b0; tick();
    check_eq("off_valid",  d_valid,       0);
    check_eq("off_active", cruise_active, 0);
    enable = 1'b1; tick();
    resume = 1'b1; tick(); resume = 1'b0;
    check_eq("resume_ignored", cruise_active, 0);

    // Reset mid-loop.
    pulse_set(80);
    run(3);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("midrst_d",      alu_d_speed,   0);
    check_eq("midrst_active", cruise_active, 0);

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 2500; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 59) != 0);
      set    = ($urandom_range(0, 24) == 0);
      resume = ($urandom_range(0, 24) == 0);
      brake  = ($urandom_range(0, 39) == 0);
      cancel = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) accel = ~accel;
      if ($urandom_range(0, 9) == 0) coast = ~coast;
      if ($urandom_range(0, 7) == 0) c_speed = 8'($urandom_range(25, 215));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
